// File: rtl/eeg_pea_pkg.sv
// Shared constants and FSM encoding for the PE activation/weight feeder.
package eeg_pea_pkg;
   localparam int ACT_DW      = 8;
   localparam int WEI_DW      = 8;
   localparam int ARAM_ADD_AW = 10;
   localparam int WRAM_ADD_AW = 8;
   localparam int CONV_WEI_DW = 3;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_WLOAD  = 3'd1,
      S_AREAD  = 3'd2,
      S_AWAIT  = 3'd3,
      S_STREAM = 3'd4
   } state_e;
endpackage

// File: rtl/eeg_pea_eng_feeder_if.sv
// Feeder bus: run configuration, weight/activation RAM read ports, PE stream.
interface eeg_pea_eng_feeder_if;
   import eeg_pea_pkg::*;

   logic                   CFG_START;
   logic [CONV_WEI_DW-1:0] CFG_CONV_WEI;
   logic [ARAM_ADD_AW-1:0] CFG_ACT_BASE;
   logic [ARAM_ADD_AW-1:0] CFG_ACT_NUM;
   logic [WRAM_ADD_AW-1:0] CFG_WEI_BASE;
   logic                   IS_IDLE;
   logic                   DONE;
   logic                   WRAM_REN;
   logic [WRAM_ADD_AW-1:0] WRAM_ADD;
   logic [WEI_DW-1:0]      WRAM_DAT;
   logic                   ARAM_REN;
   logic [ARAM_ADD_AW-1:0] ARAM_ADD;
   logic [ACT_DW-1:0]      ARAM_DAT;
   logic                   DIN_VLD;
   logic                   DIN_RDY;
   logic                   ACT_LST;
   logic                   WEI_LST;
   logic [ACT_DW-1:0]      ACT_DAT;
   logic [ARAM_ADD_AW-1:0] ACT_ADD;
   logic [WEI_DW-1:0]      WEI_DAT;
   logic [CONV_WEI_DW-1:0] WEI_IDX;

   modport slave (
      input  CFG_START, CFG_CONV_WEI, CFG_ACT_BASE, CFG_ACT_NUM, CFG_WEI_BASE,
      input  WRAM_DAT, ARAM_DAT, DIN_RDY,
      output IS_IDLE, DONE, WRAM_REN, WRAM_ADD, ARAM_REN, ARAM_ADD,
      output DIN_VLD, ACT_LST, WEI_LST, ACT_DAT, ACT_ADD, WEI_DAT, WEI_IDX
   );

   modport master (
      output CFG_START, CFG_CONV_WEI, CFG_ACT_BASE, CFG_ACT_NUM, CFG_WEI_BASE,
      output WRAM_DAT, ARAM_DAT, DIN_RDY,
      input  IS_IDLE, DONE, WRAM_REN, WRAM_ADD, ARAM_REN, ARAM_ADD,
      input  DIN_VLD, ACT_LST, WEI_LST, ACT_DAT, ACT_ADD, WEI_DAT, WEI_IDX
   );
endinterface

// File: rtl/eeg_pea_eng_feeder_wrf.sv
// Tap weight register file: one synchronous write port, one async read port.
module eeg_pea_eng_feeder_wrf #(
   parameter int DW = 8,
   parameter int AW = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);
   logic [2**AW-1:0][DW-1:0] mem_q;

   // Tap storage, cleared on reset
   always_ff @(posedge clk) begin
      if (!rst_n)    mem_q <= '0;
      else if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/eeg_pea_eng_feeder.sv
// Feeds (activation, tap weight) beats to a PE: loads all taps once, then
// streams every tap against each activation in turn.
// Optional macro EEG_PEA_FEEDER_PREFETCH_EN: prefetch the next activation into
// a shadow register so consecutive activations stream without bubbles.
module eeg_pea_eng_feeder
   import eeg_pea_pkg::*;
(
   input logic                clk,
   input logic                rst_n,
   eeg_pea_eng_feeder_if.slave bus
);
   localparam int CNT_W = CONV_WEI_DW + 1;

   state_e                 state_q, state_d;
   logic [CONV_WEI_DW-1:0] cfg_wei_q, w_q, wr_idx_q;
   logic [ARAM_ADD_AW-1:0] cfg_abase_q, cfg_anum_q, a_q;
   logic [WRAM_ADD_AW-1:0] cfg_wbase_q;
   logic [CNT_W-1:0]       cnt_q;
   logic                   wr_en_q, done_q;
   logic [ACT_DW-1:0]      act_q, shd_dat;
   logic [WEI_DW-1:0]      tap_rd;
   logic                   streaming, hs, w_lst, a_lst, wload_rd, pf_rd, shd_ok;

   assign streaming = (state_q == S_STREAM);
   assign hs        = streaming && bus.DIN_RDY;
   assign w_lst     = (w_q == cfg_wei_q);
   assign a_lst     = (a_q == cfg_anum_q);
   assign wload_rd  = (state_q == S_WLOAD) && (cnt_q <= {1'b0, cfg_wei_q});

`ifdef EEG_PEA_FEEDER_PREFETCH_EN
   logic              pf_iss_q, pf_cap_q, shd_vld_q;
   logic [ACT_DW-1:0] shd_q;

   // Next activation read goes out in the first STREAM cycle of the current one
   assign pf_rd   = streaming && !pf_iss_q && !a_lst;
   // Data still on ARAM_DAT this cycle counts as available, so a short tap
   // loop does not miss it
   assign shd_ok  = shd_vld_q || (streaming && pf_cap_q);
   assign shd_dat = shd_vld_q ? shd_q : bus.ARAM_DAT;

   // Prefetch bookkeeping and shadow capture
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pf_iss_q  <= 1'b0;
         pf_cap_q  <= 1'b0;
         shd_vld_q <= 1'b0;
         shd_q     <= '0;
      end else begin
         pf_cap_q <= pf_rd;
         if (pf_rd) pf_iss_q <= 1'b1;
         if (streaming && pf_cap_q) begin
            shd_q     <= bus.ARAM_DAT;
            shd_vld_q <= 1'b1;
         end
         if (hs && w_lst) begin
            pf_iss_q  <= 1'b0;
            shd_vld_q <= 1'b0;
         end
      end
   end
`else
   assign pf_rd   = 1'b0;
   assign shd_ok  = 1'b0;
   assign shd_dat = '0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (bus.CFG_START) state_d = S_WLOAD;
         S_WLOAD:  if (cnt_q == ({1'b0, cfg_wei_q} + CNT_W'(1))) state_d = S_AREAD;
         S_AREAD:  state_d = S_AWAIT;
         S_AWAIT:  state_d = S_STREAM;
         S_STREAM: begin
            if (hs && w_lst) begin
               if (a_lst)       state_d = S_IDLE;
               else if (shd_ok) state_d = S_STREAM;
`ifdef EEG_PEA_FEEDER_PREFETCH_EN
               else             state_d = S_AWAIT;
`else
               else             state_d = S_AREAD;
`endif
            end
         end
         default:  state_d = S_IDLE;
      endcase
   end

   // Config capture, counters, activation register and DONE pulse
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cfg_wei_q   <= '0;
         cfg_abase_q <= '0;
         cfg_anum_q  <= '0;
         cfg_wbase_q <= '0;
         cnt_q       <= '0;
         a_q         <= '0;
         w_q         <= '0;
         act_q       <= '0;
         wr_en_q     <= 1'b0;
         wr_idx_q    <= '0;
         done_q      <= 1'b0;
      end else begin
         wr_en_q  <= wload_rd;
         wr_idx_q <= cnt_q[CONV_WEI_DW-1:0];
         done_q   <= hs && w_lst && a_lst;
         unique case (state_q)
            S_IDLE: begin
               if (bus.CFG_START) begin
                  cfg_wei_q   <= bus.CFG_CONV_WEI;
                  cfg_abase_q <= bus.CFG_ACT_BASE;
                  cfg_anum_q  <= bus.CFG_ACT_NUM;
                  cfg_wbase_q <= bus.CFG_WEI_BASE;
                  cnt_q       <= '0;
                  a_q         <= '0;
                  w_q         <= '0;
               end
            end
            S_WLOAD: cnt_q <= cnt_q + CNT_W'(1);
            S_AWAIT: act_q <= bus.ARAM_DAT;
            S_STREAM: begin
               if (hs) begin
                  if (w_lst) begin
                     w_q <= '0;
                     if (!a_lst) begin
                        a_q <= a_q + ARAM_ADD_AW'(1);
                        if (shd_ok) act_q <= shd_dat;
                     end
                  end else begin
                     w_q <= w_q + CONV_WEI_DW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   eeg_pea_eng_feeder_wrf #(.DW(WEI_DW), .AW(CONV_WEI_DW)) u_wrf (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (wr_en_q),
      .waddr_i (wr_idx_q),
      .wdata_i (bus.WRAM_DAT),
      .raddr_i (w_q),
      .rdata_o (tap_rd)
   );

   assign bus.IS_IDLE  = (state_q == S_IDLE);
   assign bus.DONE     = done_q;
   assign bus.WRAM_REN = wload_rd;
   assign bus.WRAM_ADD = wload_rd ? cfg_wbase_q + WRAM_ADD_AW'(cnt_q[CONV_WEI_DW-1:0]) : '0;
   assign bus.ARAM_REN = (state_q == S_AREAD) || pf_rd;
   assign bus.ARAM_ADD = (state_q == S_AREAD) ? cfg_abase_q + a_q :
                         pf_rd ? cfg_abase_q + a_q + ARAM_ADD_AW'(1) : '0;
   assign bus.DIN_VLD  = streaming;
   assign bus.WEI_LST  = streaming && w_lst;
   assign bus.ACT_LST  = streaming && a_lst;
   assign bus.ACT_DAT  = streaming ? act_q : '0;
   assign bus.ACT_ADD  = streaming ? cfg_abase_q + a_q : '0;
   assign bus.WEI_DAT  = streaming ? tap_rd : '0;
   assign bus.WEI_IDX  = streaming ? w_q : '0;
endmodule
